mem_wb_pipeline_reg: RTL and testbench

MEM_WB_PIPELINE_REG -- requirements
Module: mem_wb_pipeline_reg

---
 rtl/rv_pipeline_pkg.sv | 13 +
 rtl/mem_wb_stage.sv | 49 ++++
 rtl/mem_wb_pipeline_reg.sv | 137 +++++++++++++
 tb/tb_mem_wb_pipeline_reg.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipeline_pkg.sv
// Shared RISC-V pipeline definitions: load funct3 encodings used by the
// MEM/WB load-extension logic.
package rv_pipeline_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

endpackage

// File: rtl/mem_wb_stage.sv
// One MEM/WB register stage: asynchronous clear, flush inserts a bubble,
// stall holds contents; flush wins over stall.
module mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_d,
    input  logic                  we_d,
    input  logic                  mem_acc_d,
    input  logic [XLEN-1:0]       mem_data_d,
    input  logic [XLEN-1:0]       alu_d,
    input  logic [REG_ADDR_W-1:0] waddr_d,
    output logic                  valid_q,
    output logic                  we_q,
    output logic                  mem_acc_q,
    output logic [XLEN-1:0]       mem_data_q,
    output logic [XLEN-1:0]       alu_q,
    output logic [REG_ADDR_W-1:0] waddr_q
);

    // NOTE: non-blocking assignments, so each stage samples its upstream
    // neighbour's pre-edge value and the chain shifts by exactly one stage.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            mem_acc_q  <= 1'b0;
            mem_data_q <= '0;
            alu_q      <= '0;
            waddr_q    <= '0;
        end else if (flush) begin
            // Only the control bits matter for a bubble; data fields are don't-care.
            valid_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (!stall) begin
            valid_q    <= valid_d;
            we_q       <= we_d;
            mem_acc_q  <= mem_acc_d;
            mem_data_q <= mem_data_d;
            alu_q      <= alu_d;
            waddr_q    <= waddr_d;
        end
    end

endmodule

// File: rtl/mem_wb_pipeline_reg.sv
// MEM/WB pipeline register: load data extension followed by DEPTH
// stall/flush-capable register stages and the writeback data select.
module mem_wb_pipeline_reg
    import rv_pipeline_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 1
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       Valid_In,
    input  logic                       Stall,
    input  logic                       Flush,
    input  logic                       Write_enable,
    input  logic                       Memory_access,
    input  logic [2:0]                 Load_Type,
    input  logic [$clog2(XLEN/8)-1:0]  Addr_Offset,
    input  logic [XLEN-1:0]            Memory_Data,
    input  logic [XLEN-1:0]            ALU_Output,
    input  logic [REG_ADDR_W-1:0]      Write_Address,
    output logic                       Valid_Out,
    output logic                       Write_Enable_Out,
    output logic                       Memory_access_Out,
    output logic [XLEN-1:0]            Memory_Data_Out,
    output logic [XLEN-1:0]            ALU_Output_Out,
    output logic [XLEN-1:0]            Wb_Data_Out,
    output logic [REG_ADDR_W-1:0]      Write_Address_out
);

    localparam int OFF_W = $clog2(XLEN/8);

    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      word_sel;
    logic [XLEN-1:0]  ext_data;
    logic             we_in;

    // Offset bits below the access size are ignored by masking them off.
    assign off_h    = Addr_Offset & ~OFF_W'(1);
    assign off_w    = Addr_Offset & ~OFF_W'(3);
    assign byte_sel = 8'(Memory_Data >> {Addr_Offset, 3'b000});
    assign half_sel = 16'(Memory_Data >> {off_h, 3'b000});
    assign word_sel = 32'(Memory_Data >> {off_w, 3'b000});

    // NOTE: ext_data gets its default first, so no path through the case
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ext_data = Memory_Data;
        if (Memory_access) begin
            case (Load_Type)
                LB: begin
                    ext_data       = {XLEN{byte_sel[7]}};
                    ext_data[7:0]  = byte_sel;
                end
                LBU: begin
                    ext_data       = '0;
                    ext_data[7:0]  = byte_sel;
                end
                LH: begin
                    ext_data       = {XLEN{half_sel[15]}};
                    ext_data[15:0] = half_sel;
                end
                LHU: begin
                    ext_data       = '0;
                    ext_data[15:0] = half_sel;
                end
                LW: begin
                    if (XLEN == 64) begin
                        ext_data       = {XLEN{word_sel[31]}};
                        ext_data[31:0] = word_sel;
                    end
                end
                LWU: begin
                    if (XLEN == 64) begin
                        ext_data       = '0;
                        ext_data[31:0] = word_sel;
                    end
                end
                // LD and codes not legal for this XLEN pass the full word.
                default: ext_data = Memory_Data;
            endcase
        end
    end

    assign we_in = Write_enable & Valid_In & (Write_Address != '0);

    // Index 0 is the stage-1 input; index i+1 is the output of stage i.
    logic [DEPTH:0]          valid_c;
    logic [DEPTH:0]          we_c;
    logic [DEPTH:0]          ma_c;
    logic [XLEN-1:0]         md_c    [0:DEPTH];
    logic [XLEN-1:0]         alu_c   [0:DEPTH];
    logic [REG_ADDR_W-1:0]   waddr_c [0:DEPTH];

    assign valid_c[0] = Valid_In;
    assign we_c[0]    = we_in;
    assign ma_c[0]    = Memory_access;
    assign md_c[0]    = ext_data;
    assign alu_c[0]   = ALU_Output;
    assign waddr_c[0] = Write_Address;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        mem_wb_stage #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_stage (
            .CLK        (CLK),
            .Reset      (Reset),
            .stall      (Stall),
            .flush      ((i == 0) ? Flush : 1'b0),
            .valid_d    (valid_c[i]),
            .we_d       (we_c[i]),
            .mem_acc_d  (ma_c[i]),
            .mem_data_d (md_c[i]),
            .alu_d      (alu_c[i]),
            .waddr_d    (waddr_c[i]),
            .valid_q    (valid_c[i+1]),
            .we_q       (we_c[i+1]),
            .mem_acc_q  (ma_c[i+1]),
            .mem_data_q (md_c[i+1]),
            .alu_q      (alu_c[i+1]),
            .waddr_q    (waddr_c[i+1])
        );
    end

    assign Valid_Out         = valid_c[DEPTH];
    assign Write_Enable_Out  = we_c[DEPTH];
    assign Memory_access_Out = ma_c[DEPTH];
    assign Memory_Data_Out   = md_c[DEPTH];
    assign ALU_Output_Out    = alu_c[DEPTH];
    assign Write_Address_out = waddr_c[DEPTH];
    assign Wb_Data_Out       = Memory_access_Out ? Memory_Data_Out : ALU_Output_Out;

endmodule

// File: tb/tb_mem_wb_pipeline_reg.sv
// Scoreboard bench for mem_wb_pipeline_reg: 32-bit DEPTH=1 and DEPTH=3
// instances share stimulus; a 64-bit DEPTH=1 instance covers wide loads.
module tb_mem_wb_pipeline_reg;
    import rv_pipeline_pkg::*;

    typedef struct {
        logic [63:0] wb;
        logic [63:0] md;
        logic [63:0] alu;
        logic        we;
        logic        ma;
        logic [4:0]  wa;
        int          cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic Reset, Stall, Flush, we, ma;
    logic [4:0] wa;

    logic        a_valid_in;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] md, alu;

    logic        c_valid_in;
    logic [2:0]  c_lt;
    logic [2:0]  c_off;
    logic [63:0] c_md, c_alu;

    logic        a_vo, a_weo, a_mao, b_vo, b_weo, b_mao, c_vo, c_weo, c_mao;
    logic [31:0] a_mdo, a_alo, a_wbo, b_mdo, b_alo, b_wbo;
    logic [63:0] c_mdo, c_alo, c_wbo;
    logic [4:0]  a_wao, b_wao, c_wao;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic stall_q  = 1'b0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        stall_q <= Stall;
    end

    mem_wb_pipeline_reg #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(1)) u_a (
        .CLK(CLK), .Reset(Reset), .Valid_In(a_valid_in), .Stall(Stall), .Flush(Flush),
        .Write_enable(we), .Memory_access(ma), .Load_Type(lt), .Addr_Offset(off),
        .Memory_Data(md), .ALU_Output(alu), .Write_Address(wa),
        .Valid_Out(a_vo), .Write_Enable_Out(a_weo), .Memory_access_Out(a_mao),
        .Memory_Data_Out(a_mdo), .ALU_Output_Out(a_alo), .Wb_Data_Out(a_wbo),
        .Write_Address_out(a_wao)
    );

    mem_wb_pipeline_reg #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(3)) u_b (
        .CLK(CLK), .Reset(Reset), .Valid_In(a_valid_in), .Stall(Stall), .Flush(Flush),
        .Write_enable(we), .Memory_access(ma), .Load_Type(lt), .Addr_Offset(off),
        .Memory_Data(md), .ALU_Output(alu), .Write_Address(wa),
        .Valid_Out(b_vo), .Write_Enable_Out(b_weo), .Memory_access_Out(b_mao),
        .Memory_Data_Out(b_mdo), .ALU_Output_Out(b_alo), .Wb_Data_Out(b_wbo),
        .Write_Address_out(b_wao)
    );

    mem_wb_pipeline_reg #(.XLEN(64), .REG_ADDR_W(5), .DEPTH(1)) u_c (
        .CLK(CLK), .Reset(Reset), .Valid_In(c_valid_in), .Stall(Stall), .Flush(Flush),
        .Write_enable(we), .Memory_access(ma), .Load_Type(c_lt), .Addr_Offset(c_off),
        .Memory_Data(c_md), .ALU_Output(c_alu), .Write_Address(wa),
        .Valid_Out(c_vo), .Write_Enable_Out(c_weo), .Memory_access_Out(c_mao),
        .Memory_Data_Out(c_mdo), .ALU_Output_Out(c_alo), .Wb_Data_Out(c_wbo),
        .Write_Address_out(c_wao)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: Valid_Out high with no instruction expected (t=%0t)", name, $time);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [63:0] wb,
                           input logic [63:0] mdo, input logic [63:0] alo,
                           input logic weo, input logic mao, input logic [4:0] wao);
        check({tag, "_wb"},    wb,        e.wb);
        check({tag, "_mdata"}, mdo,       e.md);
        check({tag, "_alu"},   alo,       e.alu);
        check({tag, "_we"},    64'(weo),  64'(e.we));
        check({tag, "_ma"},    64'(mao),  64'(e.ma));
        check({tag, "_waddr"}, 64'(wao),  64'(e.wa));
        check({tag, "_cycle"}, 64'(cyc),  64'(e.cyc));
    endtask

    // Monitors: an output is presented when Valid_Out is high after an edge
    // that was not stalled.
    always @(negedge CLK) begin
        if (Reset && a_vo && !stall_q) begin
            if (qa.size() == 0) unexpected("a_extra_output");
            else compare("a", qa.pop_front(), {32'h0, a_wbo}, {32'h0, a_mdo}, {32'h0, a_alo}, a_weo, a_mao, a_wao);
        end
        if (Reset && b_vo && !stall_q) begin
            if (qb.size() == 0) unexpected("b_extra_output");
            else compare("b", qb.pop_front(), {32'h0, b_wbo}, {32'h0, b_mdo}, {32'h0, b_alo}, b_weo, b_mao, b_wao);
        end
        if (Reset && c_vo && !stall_q) begin
            if (qc.size() == 0) unexpected("c_extra_output");
            else compare("c", qc.pop_front(), c_wbo, c_mdo, c_alo, c_weo, c_mao, c_wao);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        a_valid_in = 1'b0;
        c_valid_in = 1'b0;
        repeat (n) step();
    endtask

    // b_rel < 0: instruction is expected to be flushed inside the deep pipe.
    task automatic issue32(input logic w, input logic m, input logic [2:0] t, input logic [1:0] o,
                           input logic [31:0] d, input logic [31:0] a, input logic [4:0] r,
                           input logic [31:0] exp_md, input logic exp_we, input int b_rel);
        exp_t e;
        we = w; ma = m; lt = t; off = o; md = d; alu = a; wa = r;
        a_valid_in = 1'b1;
        c_valid_in = 1'b0;
        e.md  = {32'h0, exp_md};
        e.alu = {32'h0, a};
        e.wb  = m ? e.md : e.alu;
        e.we  = exp_we;
        e.ma  = m;
        e.wa  = r;
        e.cyc = cyc + 1;
        qa.push_back(e);
        if (b_rel >= 0) begin
            e.cyc = cyc + b_rel;
            qb.push_back(e);
        end
        step();
    endtask

    task automatic issue64(input logic w, input logic m, input logic [2:0] t, input logic [2:0] o,
                           input logic [63:0] d, input logic [63:0] a, input logic [4:0] r,
                           input logic [63:0] exp_md, input logic exp_we);
        exp_t e;
        we = w; ma = m; c_lt = t; c_off = o; c_md = d; c_alu = a; wa = r;
        c_valid_in = 1'b1;
        a_valid_in = 1'b0;
        e.md  = exp_md;
        e.alu = a;
        e.wb  = m ? exp_md : a;
        e.we  = exp_we;
        e.ma  = m;
        e.wa  = r;
        e.cyc = cyc + 1;
        qc.push_back(e);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; we = 1'b0; ma = 1'b0; wa = '0;
        a_valid_in = 1'b0; lt = '0; off = '0; md = '0; alu = '0;
        c_valid_in = 1'b0; c_lt = '0; c_off = '0; c_md = '0; c_alu = '0;

        #12;
        check("rst_a_valid", 64'(a_vo), 0);
        check("rst_a_we",    64'(a_weo), 0);
        check("rst_a_wb",    64'(a_wbo), 0);
        check("rst_a_waddr", 64'(a_wao), 0);
        check("rst_b_valid", 64'(b_vo), 0);
        check("rst_b_wb",    64'(b_wbo), 0);
        check("rst_c_valid", 64'(c_vo), 0);
        check("rst_c_wb",    c_wbo, 0);
        Reset = 1'b1;

        // 32-bit extension and write-enable vectors
        issue32(1, 1, LB,     2, 32'h12803456, 32'h0,        5,  32'hFFFFFF80, 1, 3);
        issue32(1, 0, LB,     0, 32'hDEADBEEF, 32'h87654321, 0,  32'hDEADBEEF, 0, 3);
        issue32(1, 1, LH,     3, 32'h80017FFF, 32'h1111,     6,  32'hFFFF8001, 1, 3);
        issue32(1, 1, LH,     0, 32'h80017FFF, 32'h0,        7,  32'h00007FFF, 1, 3);
        issue32(1, 1, LBU,    3, 32'hAB000000, 32'h0,        8,  32'h000000AB, 1, 3);
        issue32(1, 1, LW,     3, 32'h89ABCDEF, 32'h0,        9,  32'h89ABCDEF, 1, 3);
        issue32(1, 1, 3'b110, 1, 32'h80000001, 32'h0,        10, 32'h80000001, 1, 3);
        issue32(1, 1, 3'b011, 0, 32'hCAFEF00D, 32'h0,        11, 32'hCAFEF00D, 1, 3);
        issue32(1, 1, 3'b111, 2, 32'h7F00FF00, 32'h0,        12, 32'h7F00FF00, 1, 3);
        issue32(0, 1, LB,     0, 32'h0000007F, 32'h0,        13, 32'h0000007F, 0, 3);
        issue32(1, 1, LHU,    1, 32'h1234FFFF, 32'h0,        14, 32'h0000FFFF, 1, 3);
        idle(4);

        // Back-to-back with a two-cycle stall: deep pipe emits at cycles 3, 6, 7
        issue32(1, 0, LB, 0, 32'h0, 32'd1, 1, 32'h0, 1, 3);
        issue32(1, 0, LB, 0, 32'h0, 32'd2, 2, 32'h0, 1, 5);
        issue32(1, 0, LB, 0, 32'h0, 32'd3, 3, 32'h0, 1, 5);
        a_valid_in = 1'b0;
        Stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_b_hold_wb",    64'(b_wbo), 1);
            check("stall_b_hold_valid", 64'(b_vo), 1);
            check("stall_a_hold_wb",    64'(a_wbo), 3);
        end
        Stall = 1'b0;
        idle(5);

        // Flush together with stall clears stage 1; following LHU passes
        issue32(1, 0, LB, 0, 32'h0, 32'h77, 2, 32'h0, 1, -1);
        Flush = 1'b1; Stall = 1'b1;
        we = 1'b1; ma = 1'b1; lt = LHU; off = 2'd2; md = 32'hBEEF0000; wa = 5'd3;
        a_valid_in = 1'b1;
        step();
        check("flush_a_valid", 64'(a_vo), 0);
        check("flush_a_we",    64'(a_weo), 0);
        Flush = 1'b0; Stall = 1'b0;
        issue32(1, 1, LHU, 2, 32'hBEEF0000, 32'h0, 3, 32'h0000BEEF, 1, 3);
        idle(4);

        // Reset between edges with writes in flight
        issue32(1, 0, LB, 0, 32'h0, 32'h55, 9,  32'h0, 1, 3);
        issue32(1, 0, LB, 0, 32'h0, 32'h66, 10, 32'h0, 1, 3);
        a_valid_in = 1'b0;
        qa.delete();
        qb.delete();
        Reset = 1'b0;
        #1;
        check("midrst_a_valid", 64'(a_vo), 0);
        check("midrst_a_we",    64'(a_weo), 0);
        check("midrst_a_wb",    64'(a_wbo), 0);
        check("midrst_a_waddr", 64'(a_wao), 0);
        check("midrst_b_valid", 64'(b_vo), 0);
        check("midrst_b_we",    64'(b_weo), 0);
        check("midrst_b_wb",    64'(b_wbo), 0);
        check("midrst_b_waddr", 64'(b_wao), 0);
        step();
        step();
        Reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("postrst_a_we", 64'(a_weo), 0);
            check("postrst_b_we", 64'(b_weo), 0);
            check("postrst_b_valid", 64'(b_vo), 0);
        end
        issue32(1, 1, LBU, 0, 32'h000000C3, 32'h0, 4, 32'h000000C3, 1, 3);
        idle(4);

        // 64-bit loads
        issue64(1, 1, LWU,    4, 64'h80000000_00000000, 64'h0, 5,  64'h00000000_80000000, 1);
        issue64(1, 1, LW,     4, 64'h80000000_00000000, 64'h0, 5,  64'hFFFFFFFF_80000000, 1);
        issue64(1, 1, LD,     0, 64'h81234567_89ABCDEF, 64'h0, 6,  64'h81234567_89ABCDEF, 1);
        issue64(1, 1, LB,     7, 64'h80000000_00000000, 64'h0, 7,  64'hFFFFFFFF_FFFFFF80, 1);
        issue64(1, 1, LHU,    6, 64'hBEEF0000_00000000, 64'h0, 8,  64'h00000000_0000BEEF, 1);
        issue64(1, 1, LW,     5, 64'h7FFFFFFF_00000000, 64'h0, 9,  64'h00000000_7FFFFFFF, 1);
        issue64(1, 1, 3'b111, 3, 64'hFEDCBA98_76543210, 64'h0, 10, 64'hFEDCBA98_76543210, 1);
        issue64(1, 0, LW,     4, 64'h80000000_00000000, 64'h01234567_89ABCDEF, 11, 64'h80000000_00000000, 1);
        issue64(1, 1, LH,     2, 64'h00000000_87650000, 64'h0, 12, 64'hFFFFFFFF_FFFF8765, 1);
        idle(4);

        check("qa_drained", 64'(qa.size()), 0);
        check("qb_drained", 64'(qb.size()), 0);
        check("qc_drained", 64'(qc.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
